dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-ported data memory.
- Shares data memory between the core load/store unit (port C) and a debug/DMA loader port (port D), which initialises or inspects memory while the core runs or halts.
- Serialises accesses, handles the memory's fixed read latency, and produces a stall for the single-cycle core while its access is pending.

Parameters:
- ADDR_W, 32, byte address width on all ports.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- MEM_LAT, 1, cycles from mem_en to valid mem_rdata; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- c_req  in  1  core request; held with fields stable until c_ack.
- c_we  in  1  core write enable.
- c_addr  in  ADDR_W  core address.
- c_wdata  in  DATA_W  core write data.
- c_be  in  DATA_W/8  core byte enables.
- c_ack  out  1  one-cycle completion pulse to core.
- c_rdata  out  DATA_W  core read data, valid with c_ack.
- c_stall  out  1  combinational: c_req & ~c_ack.
- d_req, d_we, d_addr, d_wdata, d_be  in  as core fields, debug port.
- d_ack  out  1  debug completion pulse.
- d_rdata  out  DATA_W  debug read data, valid with d_ack.
- d_lock  in  1  exclusive-access request; see Optional Feature.
- mem_en  out  1  one-cycle memory strobe.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_rdata  in  DATA_W  memory read data, MEM_LAT cycles after mem_en.

Behaviour:
- Reset (rst=0, async): state IDLE; c_ack, d_ack, mem_en, mem_we = 0; c_rdata, d_rdata, mem_addr, mem_wdata, mem_be = 0; round-robin pointer = C-preferred; latency counter = 0. Reset mid-transaction aborts it and no ack is issued.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, grant one requester, register its we/addr/wdata/be, and go to ISSUE.
  - Only one requester: grant it.
  - Both requesting: grant the port the pointer prefers, then flip the pointer to the other port.
- ISSUE: mem_en=1 for exactly this cycle, memory fields driven from registers. Load counter with MEM_LAT-1. Go to RESP if MEM_LAT=1, else WAIT.
- WAIT: decrement counter each cycle; at 1, go to RESP.
- RESP:
  - Capture mem_rdata into the granted port's rdata register.
  - Pulse that port's ack this cycle; for writes, rdata is unchanged.
  - Return to IDLE.
- Latency: req seen in IDLE at edge t → mem_en in cycle t+1 → ack in cycle t+1+MEM_LAT. Minimum service time is MEM_LAT+2 cycles, including the IDLE re-arbitration cycle.
- The requester may re-assert req in the cycle after its ack; this is a new transaction.
- Abandon: if the granted port drops req before RESP, the memory access still completes but the ack is suppressed. Return to IDLE; the pointer is unchanged by the abandon.
- Request fields that change while granted are ignored (already registered).
- mem_en is never high in two consecutive cycles; exactly one ack per completed grant; c_ack and d_ack are never both high.
- c_stall is high for every cycle core req is high without ack, including while the debug port is served.

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- With macro: while d_lock=1, IDLE grants only port D and port C waits (c_stall held). d_lock rising during a core transaction takes effect at the next IDLE. Dropping d_lock restores round-robin with pointer C-preferred.
- Without macro: d_lock port present but ignored; pure round-robin.

Test Plan:
- Reset mid-WAIT (MEM_LAT=3, core read in flight), rst=0 for 2 cycles → all outputs 0, no c_ack afterwards; next core read completes normally.
- MEM_LAT=1, core read addr 0x10, memory returns 0xDEADBEEF → mem_en one cycle after req seen, c_ack with c_rdata=0xDEADBEEF one cycle later, c_stall high until c_ack.
- Both ports requesting continuously from reset, reads to 0x0/0x4 → grant order C,D,C,D; acks alternate, never coincident; mem_en never in consecutive cycles.
- Debug write addr 0x20, d_be=4'b0011, d_wdata=0x0000ABCD while core reads → mem_we=1, mem_be=0011 on D's issue; c_stall held through D service.
- Core drops c_req during WAIT (MEM_LAT=4) → no c_ack; IDLE; immediate d_req granted next cycle.
- DMEM_ARB_LOCK_EN defined, d_lock=1, both requesting for 3 D transactions → only D granted; after d_lock=0, C granted first.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port (core C, debug D) round-robin arbiter and sequencer for a fixed-latency,
// single-ported data memory. Optional debug exclusive lock: define DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                c_req,
  input  logic                c_we,
  input  logic [ADDR_W-1:0]   c_addr,
  input  logic [DATA_W-1:0]   c_wdata,
  input  logic [DATA_W/8-1:0] c_be,
  output logic                c_ack,
  output logic [DATA_W-1:0]   c_rdata,
  output logic                c_stall,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  input  logic                d_lock,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;
  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

  logic [1:0]        state;
  logic              grant_d;
  logic              ptr_d;
  logic              we_q;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] c_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              lock;
  logic              any_req;
  logic              pick_d;
  logic              granted_req;
  logic              resp_ack;

`ifdef DMEM_ARB_LOCK_EN
  assign lock = d_lock;
`else
  logic unused_lock;
  assign lock        = 1'b0;
  assign unused_lock = d_lock;
`endif

  // While locked only D may be granted; otherwise a lone requester wins, or the pointer decides a tie.
  always_comb begin
    any_req = lock ? d_req : (c_req | d_req);
    pick_d  = lock | (d_req & (~c_req | ptr_d));
  end

  assign granted_req = grant_d ? d_req : c_req;
  assign resp_ack    = (state == RESP) & granted_req;
  assign c_ack       = resp_ack & ~grant_d;
  assign d_ack       = resp_ack & grant_d;
  assign c_stall     = c_req & ~c_ack;
  assign mem_en      = (state == ISSUE);
  assign mem_we      = mem_en & we_q;
  assign c_rdata     = (c_ack & ~we_q) ? mem_rdata : c_rdata_q;
  assign d_rdata     = (d_ack & ~we_q) ? mem_rdata : d_rdata_q;

  // A granted port that drops its request abandons the access; the memory finishes on its own.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      grant_d   <= 1'b0;
      ptr_d     <= 1'b0;
      we_q      <= 1'b0;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lock) begin
            ptr_d <= 1'b0;
          end else if (c_req & d_req) begin
            ptr_d <= ~ptr_d;
          end
          if (any_req) begin
            grant_d   <= pick_d;
            we_q      <= pick_d ? d_we    : c_we;
            mem_addr  <= pick_d ? d_addr  : c_addr;
            mem_wdata <= pick_d ? d_wdata : c_wdata;
            mem_be    <= pick_d ? d_be    : c_be;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt <= LAT_LOAD;
          if (!granted_req) begin
            state <= IDLE;
          end else begin
            state <= (MEM_LAT == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (!granted_req) begin
            state <= IDLE;
          end else if (cnt == 4'd1) begin
            state <= RESP;
          end
        end
        RESP: begin
          if (resp_ack & ~we_q) begin
            if (grant_d) begin
              d_rdata_q <= mem_rdata;
            end else begin
              c_rdata_q <= mem_rdata;
            end
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter at MEM_LAT=3 with a pipelined memory model.
// Lock expectations follow DMEM_ARB_LOCK_EN.
module tb_dmem_arbiter;

  localparam int LAT = 3;

  typedef struct {
    logic        port;
    logic        rd;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        c_req, c_we, c_ack, c_stall;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic [3:0]  c_be;
  logic        d_req, d_we, d_ack, d_lock;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  logic prev_en = 1'b0;

  logic [31:0] mem [64];
  logic [31:0] pipe [LAT];
  logic        mem_loaded = 1'b0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_be(c_be),
    .c_ack(c_ack), .c_rdata(c_rdata), .c_stall(c_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_lock(d_lock),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: byte-enabled writes, read data appears LAT cycles after mem_en.
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[0]     <= 32'h11110000;
      mem[1]     <= 32'h22220004;
      mem[4]     <= 32'hDEADBEEF;
      mem[5]     <= 32'h55550014;
      mem[8]     <= 32'h12345678;
      mem_loaded <= 1'b1;
    end else if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[7:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
    pipe[0] <= mem_en ? mem[mem_addr[7:2]] : 32'hBAD0BAD0;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[LAT-1];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Scoreboard monitor: every ack must match the next expected completion.
  always @(negedge clk) begin
    exp_t e;
    if (c_ack || d_ack) begin
      checkOutput("ack_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("ack_port", 32'(d_ack), 32'(e.port));
        if (e.rd) checkOutput("ack_rdata", d_ack ? d_rdata : c_rdata, e.data);
      end
    end
    checkOutput("ack_exclusive", 32'(c_ack & d_ack), 32'd0);
    checkOutput("mem_en_back2back", 32'(prev_en & mem_en), 32'd0);
    prev_en = mem_en;
  end

  task automatic applyStimulus(input logic port, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be);
    int n = 0;
    if (!port) begin
      c_we = we; c_addr = addr; c_wdata = wdata; c_be = be; c_req = 1'b1;
    end else begin
      d_we = we; d_addr = addr; d_wdata = wdata; d_be = be; d_req = 1'b1;
    end
    @(negedge clk);
    while (!(port ? d_ack : c_ack) && n < 60) begin
      if (!port) checkOutput("c_stall_pending", 32'(c_stall), 32'd1);
      n++;
      @(negedge clk);
    end
    checkOutput(port ? "d_ack_seen" : "c_ack_seen", 32'(port ? d_ack : c_ack), 32'd1);
    if (!port) checkOutput("c_stall_at_ack", 32'(c_stall), 32'd0);
    @(posedge clk);
    #1;
    if (!port) c_req = 1'b0;
    else       d_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    rst = 1'b0; d_lock = 1'b0;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0; c_be = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset_ctrl", 32'({c_ack, d_ack, mem_en, mem_we, c_stall, mem_be}), 32'd0);
    checkOutput("reset_c_rdata", c_rdata, 32'd0);
    checkOutput("reset_d_rdata", d_rdata, 32'd0);
    checkOutput("reset_mem_addr", mem_addr, 32'd0);
    checkOutput("reset_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Solo core read 0x10 with exact timing
    exp_q.push_back('{1'b0, 1'b1, 32'hDEADBEEF});
    fork
      applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 4'hF);
      begin
        @(negedge clk);
        checkOutput("solo_no_en_yet", 32'(mem_en), 32'd0);
        @(negedge clk);
        checkOutput("solo_issue", 32'({mem_en, mem_we}), 32'b10);
        checkOutput("solo_issue_addr", mem_addr, 32'h10);
        repeat (LAT) @(negedge clk);
        checkOutput("solo_ack_latency", 32'(c_ack), 32'd1);
        checkOutput("solo_rdata", c_rdata, 32'hDEADBEEF);
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // Reset while a core read sits in WAIT
    c_we = 1'b0; c_addr = 32'h14; c_req = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0; c_req = 1'b0;
    @(negedge clk);
    checkOutput("midreset_ctrl", 32'({c_ack, d_ack, mem_en, mem_we, c_stall, mem_be}), 32'd0);
    checkOutput("midreset_addr", mem_addr, 32'd0);
    checkOutput("midreset_c_rdata", c_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (8) begin
      @(negedge clk);
      checkOutput("no_ack_after_reset", 32'(c_ack), 32'd0);
    end
    @(posedge clk); #1;
    exp_q.push_back('{1'b0, 1'b1, 32'h55550014});
    applyStimulus(1'b0, 1'b0, 32'h14, 32'h0, 4'hF);
    repeat (2) @(posedge clk);
    #1;

    // Both ports requesting continuously: C,D,C,D
    exp_q.push_back('{1'b0, 1'b1, 32'h11110000});
    exp_q.push_back('{1'b1, 1'b1, 32'h22220004});
    exp_q.push_back('{1'b0, 1'b1, 32'h11110000});
    exp_q.push_back('{1'b1, 1'b1, 32'h22220004});
    fork
      begin
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
      end
      begin
        applyStimulus(1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
        applyStimulus(1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // Debug partial write wins the tie (pointer now prefers D); core read sees merged word
    exp_q.push_back('{1'b1, 1'b0, 32'h0});
    exp_q.push_back('{1'b0, 1'b1, 32'h1234ABCD});
    fork
      applyStimulus(1'b0, 1'b0, 32'h20, 32'h0, 4'hF);
      applyStimulus(1'b1, 1'b1, 32'h20, 32'h0000ABCD, 4'b0011);
      begin
        n = 0;
        @(negedge clk);
        while (!mem_en && n < 20) begin n++; @(negedge clk); end
        checkOutput("d_write_issue", 32'({mem_en, mem_we, mem_be}), 32'b1_1_0011);
        checkOutput("d_write_addr", mem_addr, 32'h20);
        checkOutput("d_write_data", mem_wdata, 32'h0000ABCD);
        n = 0;
        while (!d_ack && n < 20) begin n++; @(negedge clk); end
        checkOutput("c_stall_during_d", 32'(c_stall), 32'd1);
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // Core abandons during WAIT; debug request is granted straight after
    c_we = 1'b0; c_addr = 32'h0; c_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("abandon_c_issue", 32'(mem_en), 32'd1);
    @(posedge clk); #1;
    c_req = 1'b0;
    exp_q.push_back('{1'b1, 1'b1, 32'h22220004});
    d_we = 1'b0; d_addr = 32'h4; d_be = 4'hF; d_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("abandon_idle_gap", 32'(mem_en), 32'd0);
    @(negedge clk);
    checkOutput("d_grant_after_abandon", 32'(mem_en), 32'd1);
    checkOutput("d_grant_addr", mem_addr, 32'h4);
    n = 0;
    while (!d_ack && n < 20) begin n++; @(negedge clk); end
    checkOutput("abandon_d_ack", 32'(d_ack), 32'd1);
    @(posedge clk); #1 d_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Debug lock: three locked D transactions, then unlock with both requesting
`ifdef DMEM_ARB_LOCK_EN
    exp_q.push_back('{1'b1, 1'b1, 32'h22220004});
    exp_q.push_back('{1'b1, 1'b1, 32'h22220004});
    exp_q.push_back('{1'b1, 1'b1, 32'h22220004});
    exp_q.push_back('{1'b0, 1'b1, 32'hDEADBEEF});
    exp_q.push_back('{1'b1, 1'b1, 32'h22220004});
`else
    exp_q.push_back('{1'b0, 1'b1, 32'hDEADBEEF});
    exp_q.push_back('{1'b1, 1'b1, 32'h22220004});
    exp_q.push_back('{1'b1, 1'b1, 32'h22220004});
    exp_q.push_back('{1'b1, 1'b1, 32'h22220004});
    exp_q.push_back('{1'b1, 1'b1, 32'h22220004});
`endif
    fork
      applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 4'hF);
      begin
        d_lock = 1'b1;
        repeat (3) applyStimulus(1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
        d_lock = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
      end
    join
    repeat (4) @(negedge clk);

    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
